ddr_port_arb: RTL and testbench

//   Four-port arbiter in front of the DDR controller, sharing its single request/ack command port between requesters.
//   - Selects one pending request, latches its command and presents it downstream until acked.
//   - Prefers requests that hit the currently open row (saves PRE/ACT), with a starvation bound.
//   - Routes each returned read beat to the requester that issued the read.

---
 rtl/ddr_port_arb_if.sv | 31 +++
 rtl/ddr_port_arb.sv | 173 +++++++++++++++++
 tb/tb_ddr_port_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_port_arb_if.sv
// ddr_port_arb_if: bundles the four requester ports, the per-port return path
// and the single downstream DDR command/read-data port of the arbiter.
interface ddr_port_arb_if;
   logic [3:0]   req;
   logic [3:0]   write;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic [3:0]   gnt;
   logic [3:0]   rd_valid;
   logic [63:0]  rdata;
   logic         tag_err;
   logic         m_req;
   logic         m_ack;
   logic         m_write;
   logic [7:0]   m_addr;
   logic [63:0]  m_wdata;
   logic         m_rd_en;
   logic [63:0]  m_rdata;

   // Arbiter side: serves the requesters and drives the DDR command port.
   modport slave (
      input  req, write, addr, wdata, m_ack, m_rd_en, m_rdata,
      output gnt, rd_valid, rdata, tag_err, m_req, m_write, m_addr, m_wdata
   );

   // Environment side: requesters plus the DDR controller.
   modport master (
      output req, write, addr, wdata, m_ack, m_rd_en, m_rdata,
      input  gnt, rd_valid, rdata, tag_err, m_req, m_write, m_addr, m_wdata
   );
endinterface

// File: rtl/ddr_port_arb.sv
// ddr_port_arb: four-port arbiter in front of one DDR command port. Prefers
// requests hitting the open row (bounded by HIT_MAX while a miss waits), holds
// the issued command frozen for HOLD_CYC cycles, and routes read beats back
// through a small tag FIFO.
module ddr_port_arb #(
   parameter int HOLD_CYC  = 10,
   parameter int HIT_MAX   = 4,
   parameter int TAG_DEPTH = 2
) (
   input logic           clk,
   input logic           rstn,
   ddr_port_arb_if.slave io_bus
);
   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int HC_W  = $clog2(HIT_MAX + 1);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [HC_W-1:0]  HIT_SAT   = HC_W'(HIT_MAX);
   localparam logic [PTR_W:0]   TAG_FULL  = (PTR_W + 1)'(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_sel;
   logic [1:0]        r_rr_ptr;
   logic [3:0]        r_open_row;
   logic              r_row_valid;
   logic [HC_W-1:0]   r_hit_cnt;
   logic              r_m_write;
   logic [7:0]        r_m_addr;
   logic [63:0]       r_m_wdata;
   logic [1:0]        r_tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_tag_err;

   logic [7:0]        w_addr_p  [4];
   logic [63:0]       w_wdata_p [4];
   logic [3:0]        w_elig, w_hit, w_mask;
   logic              w_full, w_use_hit, w_load, w_accept, w_m_req;
   logic              w_push, w_pop;
   logic [1:0]        w_win, w_head;

   assign w_full = (r_count == TAG_FULL);

   // Per-port views of the packed request buses plus row-hit detection.
   for (genvar gi = 0; gi < 4; gi++) begin : g_port
      assign w_addr_p[gi]  = io_bus.addr[8*gi +: 8];
      assign w_wdata_p[gi] = io_bus.wdata[64*gi +: 64];
      // A full tag FIFO blocks reads only; writes need no return slot.
      assign w_elig[gi]    = io_bus.req[gi] & (io_bus.write[gi] | ~w_full);
      assign w_hit[gi]     = w_elig[gi] & r_row_valid & (w_addr_p[gi][7:4] == r_open_row);
   end

   // Row hits win unless the hit streak is exhausted while a miss is waiting.
   assign w_use_hit = (w_hit != 4'b0) && ((r_hit_cnt < HIT_SAT) || (w_hit == w_elig));
   assign w_mask    = w_use_hit ? w_hit : w_elig;

   // Round-robin pick: first set bit of w_mask at or after r_rr_ptr.
   always_comb begin
      w_win = r_rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (w_mask[r_rr_ptr + 2'(k)]) w_win = r_rr_ptr + 2'(k);
      end
   end

   // Next-state and command-port control for IDLE -> ISSUE -> HOLD.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_accept     = 1'b0;
      w_m_req      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_elig != 4'b0) begin
               w_load       = 1'b1;
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            w_m_req = 1'b1;
            if (io_bus.m_ack) begin
               w_accept     = 1'b1;
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (r_cnt == HOLD_LAST) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // FSM state, hold counter and the latched downstream command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sel     <= '0;
         r_m_write <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_sel     <= w_win;
            r_m_write <= io_bus.write[w_win];
            r_m_addr  <= w_addr_p[w_win];
            r_m_wdata <= w_wdata_p[w_win];
         end
         if (w_accept)              r_cnt <= '0;
         else if (r_state == HOLD)  r_cnt <= r_cnt + 1'b1;
      end
   end

   // Open-row tracking, round-robin pointer and the row-hit streak counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr    <= '0;
         r_open_row  <= '0;
         r_row_valid <= 1'b0;
         r_hit_cnt   <= '0;
      end else begin
         if (w_load) begin
            if (w_use_hit && ((w_elig & ~w_hit) != 4'b0)) begin
               if (r_hit_cnt != HIT_SAT) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
               r_hit_cnt <= '0;
            end
         end
         if (w_accept) begin
            r_rr_ptr    <= r_sel + 2'd1;
            r_open_row  <= r_m_addr[7:4];
            r_row_valid <= 1'b1;
         end
      end
   end

   assign w_push = w_accept & ~r_m_write;
   assign w_pop  = io_bus.m_rd_en & (r_count != '0);
   assign w_head = r_tag_mem[r_rd_ptr];

   // Tag FIFO pointers and occupancy; push+pop together leaves count unchanged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_tag_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         if (io_bus.m_rd_en && (r_count == '0)) r_tag_err <= 1'b1;
      end
   end

   // Tag storage: the port index of each outstanding read, in issue order.
   always_ff @(posedge clk) begin
      if (w_push) r_tag_mem[r_wr_ptr] <= r_sel;
   end

   assign io_bus.m_req    = w_m_req;
   assign io_bus.m_write  = r_m_write;
   assign io_bus.m_addr   = r_m_addr;
   assign io_bus.m_wdata  = r_m_wdata;
   assign io_bus.gnt      = w_accept ? (4'b0001 << r_sel) : 4'b0000;
   assign io_bus.rd_valid = w_pop ? (4'b0001 << w_head) : 4'b0000;
   assign io_bus.rdata    = w_pop ? io_bus.m_rdata : 64'd0;
   assign io_bus.tag_err  = r_tag_err;
endmodule

// File: tb/tb_ddr_port_arb.sv
// tb_ddr_port_arb: directed scenarios for the arbiter plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_ddr_port_arb;
   localparam int HOLD_CYC  = 10;
   localparam int HIT_MAX   = 4;
   localparam int TAG_DEPTH = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   ddr_port_arb_if bus();

   ddr_port_arb #(.HOLD_CYC(HOLD_CYC), .HIT_MAX(HIT_MAX), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // First port set in mask at or after 'from', cyclically.
   function automatic int pick(logic [3:0] m, int from);
      for (int k = 0; k < 4; k++) if (m[(from + k) % 4]) return (from + k) % 4;
      return 0;
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      bus.req = '0; bus.write = '0; bus.addr = '0; bus.wdata = '0;
      bus.m_ack = 1'b0; bus.m_rd_en = 1'b0; bus.m_rdata = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_port(input int p, input logic wr, input logic [7:0] a, input logic [63:0] d);
      bus.req[p]          = 1'b1;
      bus.write[p]        = wr;
      bus.addr[8*p +: 8]  = a;
      bus.wdata[64*p +: 64] = d;
   endtask

   // Wait (bounded) for m_req, ack it, return the grant seen and drop that request.
   task automatic accept(output logic [3:0] g, output logic [7:0] a, output logic w);
      int n;
      n = 0; g = '0; a = '0; w = 1'b0;
      while (bus.m_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      if (bus.m_req === 1'b1) begin
         a = bus.m_addr; w = bus.m_write;
         bus.m_ack = 1'b1; #1; g = bus.gnt;
         @(negedge clk);
         bus.m_ack = 1'b0;
         bus.req = bus.req & ~g;
      end
   endtask

   task automatic pop(input logic [63:0] d, output logic [3:0] v, output logic [63:0] r);
      bus.m_rd_en = 1'b1; bus.m_rdata = d; #1;
      v = bus.rd_valid; r = bus.rdata;
      @(negedge clk);
      bus.m_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.m_req, bus.m_write, bus.m_addr, bus.m_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_cmd: m_req=%0b m_write=%0b m_addr=%h m_wdata=%h, want all 0",
                  bus.m_req, bus.m_write, bus.m_addr, bus.m_wdata);
      end
      checks++;
      if ({bus.gnt, bus.rd_valid, bus.rdata, bus.tag_err} !== '0) begin
         failures++;
         $display("FAIL reset_out: gnt=%b rd_valid=%b rdata=%h tag_err=%0b, want all 0",
                  bus.gnt, bus.rd_valid, bus.rdata, bus.tag_err);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      set_port(0, 1'b1, 8'h35, 64'hA5);
      @(negedge clk);
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 8'h35 || bus.m_write !== 1'b1 || bus.m_wdata !== 64'hA5) begin
         failures++;
         $display("FAIL t1_cmd: m_req=%0b m_addr=%h m_write=%0b m_wdata=%h, want 1 35 1 a5",
                  bus.m_req, bus.m_addr, bus.m_write, bus.m_wdata);
      end
      bus.m_ack = 1'b1; #1;
      checks++;
      if (bus.gnt !== 4'b0001) begin
         failures++; $display("FAIL t1_gnt: gnt=%b, want 0001", bus.gnt);
      end
      @(negedge clk);
      bus.m_ack = 1'b0; bus.req = '0;
      checks++;
      if (bus.m_req !== 1'b0) begin
         failures++; $display("FAIL t1_hold: m_req=%0b, want 0", bus.m_req);
      end
      // A write pushes no tag, so a read return now hits an empty FIFO.
      bus.m_rd_en = 1'b1; bus.m_rdata = 64'h1234; #1;
      checks++;
      if (bus.rd_valid !== 4'b0000) begin
         failures++; $display("FAIL t1_notag: rd_valid=%b, want 0000", bus.rd_valid);
      end
      @(negedge clk);
      bus.m_rd_en = 1'b0;
      checks++;
      if (bus.tag_err !== 1'b1) begin
         failures++; $display("FAIL t1_tag_err: tag_err=%0b, want 1", bus.tag_err);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0]  ad [4];
      logic [63:0] dd [4];
      logic [3:0]  g, v;
      logic [7:0]  a;
      logic [63:0] r;
      logic        w;
      do_reset();
      for (int p = 0; p < 4; p++) begin
         ad[p] = {4'(p + 1), 4'($urandom_range(15))};
         dd[p] = {$urandom, $urandom};
         set_port(p, 1'b0, ad[p], 64'd0);
      end
      for (int i = 0; i < 4; i++) begin
         accept(g, a, w);
         checks++;
         if (g !== 4'(1 << i) || a !== ad[i] || w !== 1'b0) begin
            failures++;
            $display("FAIL t2_grant%0d: gnt=%b addr=%h write=%0b, want %b %h 0", i, g, a, w, 4'(1 << i), ad[i]);
         end
         if (i >= 1) begin
            pop(dd[i-1], v, r);
            checks++;
            if (v !== 4'(1 << (i - 1)) || r !== dd[i-1]) begin
               failures++;
               $display("FAIL t2_ret%0d: rd_valid=%b rdata=%h, want %b %h", i - 1, v, r, 4'(1 << (i - 1)), dd[i-1]);
            end
         end
      end
      pop(dd[3], v, r);
      checks++;
      if (v !== 4'b1000 || r !== dd[3]) begin
         failures++; $display("FAIL t2_ret3: rd_valid=%b rdata=%h, want 1000 %h", v, r, dd[3]);
      end
   endtask

   task automatic test_row_hit();
      logic [3:0] g;
      logic [7:0] a;
      logic       w;
      do_reset();
      set_port(3, 1'b1, 8'h27, 64'd1);
      accept(g, a, w);                    // opens row 2, rr_ptr -> 0
      set_port(0, 1'b0, 8'h51, 64'd0);
      set_port(3, 1'b1, 8'h2C, 64'd2);
      accept(g, a, w);
      checks++;
      if (g !== 4'b1000 || a !== 8'h2C) begin
         failures++; $display("FAIL t3_hit_first: gnt=%b addr=%h, want 1000 2c", g, a);
      end
      accept(g, a, w);
      checks++;
      if (g !== 4'b0001 || a !== 8'h51) begin
         failures++; $display("FAIL t3_miss_next: gnt=%b addr=%h, want 0001 51", g, a);
      end
   endtask

   task automatic test_starvation();
      int         exp_seq [5] = '{3, 1, 2, 3, 0};
      logic [3:0] g;
      logic [7:0] a;
      logic       w;
      do_reset();
      set_port(2, 1'b1, 8'h20, 64'd0);
      accept(g, a, w);                    // opens row 2, rr_ptr -> 3
      set_port(0, 1'b1, 8'h70, 64'd7);
      for (int p = 1; p < 4; p++) set_port(p, 1'b1, {4'h2, 4'(p)}, 64'(p));
      for (int i = 0; i < 5; i++) begin
         accept(g, a, w);
         checks++;
         if (g !== 4'(1 << exp_seq[i])) begin
            failures++; $display("FAIL t4_grant%0d: gnt=%b, want %b", i, g, 4'(1 << exp_seq[i]));
         end
         for (int p = 1; p < 4; p++) if (g[p]) set_port(p, 1'b1, {4'h2, 4'($urandom_range(15))}, 64'(p));
      end
   endtask

   task automatic test_hold();
      logic [3:0]  g;
      logic [7:0]  a;
      logic        w;
      logic [63:0] d;
      d = {$urandom, $urandom};
      do_reset();
      set_port(1, 1'b1, 8'h4A, d);
      accept(g, a, w);
      checks++;
      if (g !== 4'b0010) begin
         failures++; $display("FAIL t5_gnt: gnt=%b, want 0010", g);
      end
      set_port(2, 1'b0, 8'h9C, 64'd0);
      for (int k = 0; k < HOLD_CYC; k++) begin
         checks++;
         if (bus.m_req !== 1'b0 || bus.m_addr !== 8'h4A || bus.m_write !== 1'b1 || bus.m_wdata !== d) begin
            failures++;
            $display("FAIL t5_frozen%0d: m_req=%0b m_addr=%h m_write=%0b m_wdata=%h, want 0 4a 1 %h",
                     k, bus.m_req, bus.m_addr, bus.m_write, bus.m_wdata, d);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.m_req !== 1'b0) begin
         failures++; $display("FAIL t5_idle: m_req=%0b, want 0", bus.m_req);
      end
      @(negedge clk);
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 8'h9C || bus.m_write !== 1'b0) begin
         failures++;
         $display("FAIL t5_next: m_req=%0b m_addr=%h m_write=%0b, want 1 9c 0", bus.m_req, bus.m_addr, bus.m_write);
      end
   endtask

   task automatic test_errors_reset();
      do_reset();
      bus.m_rd_en = 1'b1; bus.m_rdata = 64'hDEAD; #1;
      checks++;
      if (bus.rd_valid !== 4'b0000 || bus.rdata !== 64'd0) begin
         failures++; $display("FAIL t6_empty_ret: rd_valid=%b rdata=%h, want 0000 0", bus.rd_valid, bus.rdata);
      end
      @(negedge clk);
      bus.m_rd_en = 1'b0;
      checks++;
      if (bus.tag_err !== 1'b1) begin
         failures++; $display("FAIL t6_tag_err: tag_err=%0b, want 1", bus.tag_err);
      end
      set_port(0, 1'b0, 8'h11, 64'd0);
      @(negedge clk);
      checks++;
      if (bus.m_req !== 1'b1) begin
         failures++; $display("FAIL t6_issue: m_req=%0b, want 1", bus.m_req);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (bus.m_req !== 1'b0 || bus.tag_err !== 1'b0 || bus.m_addr !== 8'h00) begin
         failures++;
         $display("FAIL t6_async_rst: m_req=%0b tag_err=%0b m_addr=%h, want 0 0 00", bus.m_req, bus.tag_err, bus.m_addr);
      end
      bus.req = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_req !== 1'b0) begin
         failures++; $display("FAIL t6_dropped: m_req=%0b, want 0", bus.m_req);
      end
   endtask

   // Randomized traffic against a model of the arbitration rules. Model phase
   // 0/1/2 = waiting / command presented / hold window; decisions use the
   // request set and FIFO occupancy the arbiter saw at the selecting edge.
   task automatic test_random();
      int          ph, hc, sel, rr, hit_cnt, q_prev, sel_qsize, n_acc;
      int          tq[$];
      bit          row_valid, acked, ack, rd;
      logic [3:0]  open_row, elig, hit, exp_g, exp_v, gnt_prev;
      logic [7:0]  e_addr, a;
      logic        e_write, e_req;
      logic [63:0] e_wdata, d, exp_r;
      do_reset();
      ph = 0; hc = 0; sel = 0; rr = 0; hit_cnt = 0; q_prev = 0; n_acc = 0;
      row_valid = 0; acked = 0; open_row = '0; gnt_prev = '0;
      e_addr = '0; e_write = 1'b0; e_wdata = '0;
      for (int step = 0; step < 3000; step++) begin
         @(negedge clk);
         sel_qsize = q_prev;
         q_prev    = tq.size();
         if (ph == 0) begin
            elig = '0;
            for (int p = 0; p < 4; p++)
               if (bus.req[p] && (bus.write[p] || sel_qsize < TAG_DEPTH)) elig[p] = 1'b1;
            if (elig != 0) begin
               hit = '0;
               for (int p = 0; p < 4; p++)
                  if (elig[p] && row_valid && bus.addr[8*p+4 +: 4] == open_row) hit[p] = 1'b1;
               if (hit != 0 && (hit_cnt < HIT_MAX || hit == elig)) begin
                  sel = pick(hit, rr);
                  if ((elig & ~hit) != 0) hit_cnt = (hit_cnt < HIT_MAX) ? hit_cnt + 1 : HIT_MAX;
                  else hit_cnt = 0;
               end else begin
                  sel = pick(elig, rr);
                  hit_cnt = 0;
               end
               ph = 1;
               e_addr  = bus.addr[8*sel +: 8];
               e_write = bus.write[sel];
               e_wdata = bus.wdata[64*sel +: 64];
            end
         end else if (ph == 1) begin
            if (acked) begin ph = 2; hc = 0; end
         end else begin
            if (hc == HOLD_CYC - 1) ph = 0; else hc++;
         end
         e_req = (ph == 1);
         checks++;
         if (bus.m_req !== e_req || bus.m_addr !== e_addr || bus.m_write !== e_write || bus.m_wdata !== e_wdata) begin
            failures++;
            $display("FAIL rnd_cmd step %0d: m_req=%0b m_addr=%h m_write=%0b m_wdata=%h, want %0b %h %0b %h",
                     step, bus.m_req, bus.m_addr, bus.m_write, bus.m_wdata, e_req, e_addr, e_write, e_wdata);
         end
         bus.req = bus.req & ~gnt_prev;
         for (int p = 0; p < 4; p++) begin
            if (!bus.req[p] && $urandom_range(3) == 0) begin
               a = {4'($urandom_range(3)), 4'($urandom_range(15))};
               set_port(p, 1'($urandom_range(1)), a, {$urandom, $urandom});
            end
         end
         ack = (ph == 1) && ($urandom_range(1) == 1);
         rd  = (tq.size() > 0) && ($urandom_range(2) == 0);
         d   = {$urandom, $urandom};
         bus.m_ack = ack; bus.m_rd_en = rd; bus.m_rdata = d;
         #1;
         exp_g = ack ? 4'(1 << sel) : 4'b0000;
         checks++;
         if (bus.gnt !== exp_g) begin
            failures++; $display("FAIL rnd_gnt step %0d: gnt=%b, want %b", step, bus.gnt, exp_g);
         end
         exp_v = rd ? 4'(1 << tq[0]) : 4'b0000;
         exp_r = rd ? d : 64'd0;
         checks++;
         if (bus.rd_valid !== exp_v || bus.rdata !== exp_r) begin
            failures++;
            $display("FAIL rnd_ret step %0d: rd_valid=%b rdata=%h, want %b %h", step, bus.rd_valid, bus.rdata, exp_v, exp_r);
         end
         if (rd) void'(tq.pop_front());
         if (ack) begin
            rr = (sel + 1) % 4;
            open_row = e_addr[7:4];
            row_valid = 1;
            if (!e_write) tq.push_back(sel);
            n_acc++;
         end
         acked = ack;
         gnt_prev = exp_g;
      end
      bus.m_ack = 1'b0; bus.m_rd_en = 1'b0;
      checks++;
      if (n_acc < 50) begin
         failures++; $display("FAIL rnd_progress: accepts=%0d, want >= 50", n_acc);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_row_hit();
      test_starvation();
      test_hold();
      test_errors_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
